// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Steers byte/half/word stores onto the byte lanes of a word-wide memory,
// extracts and extends loads, and stalls the pipeline across a req/ack access.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic              stall,
    output logic [31:0]       read_data,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic              access;
    logic              aligned;
    logic              capture;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [31:0]       read_data_q, read_data_d;

    logic [31:0]       wdata_d;
    logic [3:0]        wstrb_d;
    logic [7:0]        lane8;
    logic [15:0]       lane16;

    assign access = valid_in & (mem_read | mem_write);

    // Alignment check: bytes always aligned, halves need addr[0]=0, words (and size 11) addr[1:0]=0
    always_comb begin
        unique case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign capture = (state_q == IDLE) & access & aligned;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (access && aligned) state_d = REQ;
            REQ:     if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs: stall and misaligned depend on state and live inputs
    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall      = access & aligned;
                misaligned = access & ~aligned;
            end
            REQ:     stall = 1'b1;
            default: ;
        endcase
    end

    // Store lane steering: replicate data across lanes, strobe only the addressed bytes
    always_comb begin
        unique case (size)
            2'b00: begin
                wdata_d = {4{write_data[7:0]}};
                wstrb_d = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_d = {2{write_data[15:0]}};
                wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_d = write_data;
                wstrb_d = 4'b1111;
            end
        endcase
    end

    // Load extraction and extension from the acknowledged memory word
    always_comb begin
        lane8  = mem_rdata[{off_q, 3'b000} +: 8];
        lane16 = mem_rdata[{off_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'b00:   read_data_d = sign_ext_q ? {{24{lane8[7]}}, lane8}
                                              : {24'h000000, lane8};
            2'b01:   read_data_d = sign_ext_q ? {{16{lane16[15]}}, lane16}
                                              : {16'h0000, lane16};
            default: read_data_d = mem_rdata;
        endcase
    end

    // Command capture, request flag and load result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sign_ext_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            mem_req_q <= (state_d == REQ);
            if (capture) begin
                mem_we_q    <= mem_write;
                mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata_q <= wdata_d;
                mem_wstrb_q <= mem_write ? wstrb_d : 4'b0000;
                off_q       <= addr[1:0];
                size_q      <= size;
                sign_ext_q  <= sign_ext;
            end
            if ((state_q == REQ) && mem_ack && !mem_we_q) begin
                read_data_q <= read_data_d;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        stall;
    logic [31:0] read_data;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int unsigned total;
    int unsigned passed;
    int unsigned req_hi;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .write_data (write_data),
        .stall      (stall),
        .read_data  (read_data),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which the request is high, to spot duplicated or spurious requests
    always @(negedge clk) if (mem_req) req_hi++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one aligned access starting at a negedge in IDLE; acks after 'waits' REQ cycles.
    // Ends at the negedge of the cycle after DONE with the command removed.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sx, input logic [31:0] a, input logic [31:0] wd,
                              input int unsigned waits, input logic [31:0] rdata,
                              output int unsigned stalls, output logic req_we,
                              output logic [31:0] req_addr, output logic [31:0] req_wdata,
                              output logic [3:0] req_strb);
        int unsigned n;
        valid_in   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        size       = sz;
        sign_ext   = sx;
        addr       = a;
        write_data = wd;
        stalls     = 0;
        #1;
        if (stall) stalls++;
        next_cycle();
        req_we    = mem_we;
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
        req_strb  = mem_wstrb;
        n = 0;
        while (mem_req && n < 20) begin
            mem_ack   = (n == waits);
            mem_rdata = (n == waits) ? rdata : 32'h5A5A5A5A;
            #1;
            if (stall) stalls++;
            next_cycle();
            mem_ack = 1'b0;
            n++;
        end
        check("req_cycles", n, waits + 1);
        #1;
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_req", {31'b0, mem_req}, 32'd0);
        next_cycle();
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    int unsigned stalls;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_strb;
    int unsigned req_base;

    initial begin
        total = 0; passed = 0; req_hi = 0;
        rst_n = 1'b0; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'b00; sign_ext = 1'b0; addr = '0; write_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        next_cycle();
        next_cycle();
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load, two wait cycles
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("wl_stalls", stalls, 32'd4);
        check("wl_addr", r_addr, 32'h100);
        check("wl_we", {31'b0, r_we}, 32'd0);
        check("wl_wstrb", {28'b0, r_strb}, 32'd0);
        check("wl_rdata", read_data, 32'hDEADBEEF);

        // Signed and unsigned byte loads from lane 3
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80112233,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("lbs_rdata", read_data, 32'hFFFFFF80);
        check("lbs_addr", r_addr, 32'h100);
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80112233,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("lbu_rdata", read_data, 32'h00000080);

        // Signed half load from the upper half, size 11 word load
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1, 32'h80112233,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("lhs_rdata", read_data, 32'hFFFF8011);
        check("lhs_stalls", stalls, 32'd3);
        run_access(1'b1, 1'b0, 2'b11, 1'b1, 32'h104, 32'h0, 0, 32'h13572468,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("lw11_rdata", read_data, 32'h13572468);

        // Half store to upper half: read_data must keep the last load result
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 0, 32'hFFFFFFFF,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("sh_addr", r_addr, 32'h200);
        check("sh_wdata", r_wdata, 32'hABCDABCD);
        check("sh_wstrb", {28'b0, r_strb}, 32'hC);
        check("sh_we", {31'b0, r_we}, 32'd1);
        check("sh_rdata_keep", read_data, 32'h13572468);

        // Misaligned word load: one-cycle pulse, no stall, no request
        req_base = req_hi;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h101;
        #1;
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_stall", {31'b0, stall}, 32'd0);
        next_cycle();
        valid_in = 1'b0; mem_read = 1'b0;
        #1;
        check("mis_clear", {31'b0, misaligned}, 32'd0);
        next_cycle();
        next_cycle();
        #1;
        check("mis_noreq", req_hi - req_base, 32'd0);
        check("mis_rdata_keep", read_data, 32'h13572468);
        @(negedge clk);

        // Misaligned half store
        valid_in = 1'b1; mem_write = 1'b1; size = 2'b01; addr = 32'h203;
        #1;
        check("mis_sh_pulse", {31'b0, misaligned}, 32'd1);
        next_cycle();
        valid_in = 1'b0; mem_write = 1'b0;

        // Reset while waiting in REQ, then a late ack
        valid_in = 1'b1; mem_read = 1'b1; size = 2'b10; addr = 32'h300;
        next_cycle();
        #1;
        check("rq_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1; valid_in = 1'b0; mem_read = 1'b0;
        #1;
        check("rq_req_after_rst", {31'b0, mem_req}, 32'd0);
        check("rq_stall_after_rst", {31'b0, stall}, 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        next_cycle();
        mem_ack = 1'b0;
        #1;
        check("rq_late_ack_rdata", read_data, 32'h0);
        check("rq_late_ack_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 32'hCAFEF00D,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("rq_next_rdata", read_data, 32'hCAFEF00D);
        check("rq_next_stalls", stalls, 32'd2);

        // Back-to-back byte stores with immediate acks
        req_base = req_hi;
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000A5, 0, 32'h0,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("sb0_wstrb", {28'b0, r_strb}, 32'h1);
        check("sb0_wdata", r_wdata, 32'hA5A5A5A5);
        check("sb0_addr", r_addr, 32'h10);
        check("sb0_stalls", stalls, 32'd2);
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000003C, 0, 32'h0,
                   stalls, r_we, r_addr, r_wdata, r_strb);
        check("sb1_wstrb", {28'b0, r_strb}, 32'h2);
        check("sb1_wdata", r_wdata, 32'h3C3C3C3C);
        check("sb1_stalls", stalls, 32'd2);
        #1;
        check("sb_req_count", req_hi - req_base, 32'd2);
        check("sb_rdata_keep", read_data, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
